// File: rtl/sop_arb_pkg.sv
// Shared types and constants for the SOP evaluator arbiter.
package sop_arb_pkg;

  // Operand width presented to the shared evaluator.
  localparam int unsigned OPND_W = 4;

  // Bit positions of the evaluator inputs within an operand nibble.
  localparam int unsigned X1_B = 3;
  localparam int unsigned X2_B = 2;
  localparam int unsigned X3_B = 1;
  localparam int unsigned X4_B = 0;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StResp
  } state_e;

endpackage

// File: rtl/sop_eval_arbiter_if.sv
// Requester and evaluator bus of the SOP evaluator arbiter.
interface sop_eval_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  import sop_arb_pkg::*;

  logic [N_REQ-1:0]        req;
  logic [OPND_W*N_REQ-1:0] opnd;
  logic [N_REQ-1:0]        gnt;
  logic [OPND_W-1:0]       ev_x;
  logic                    ev_z;
  logic [N_REQ-1:0]        done;
  logic                    result;
  logic                    busy;

  // Requesters plus the evaluator output: everything that feeds the arbiter.
  modport master (
    output req,
    output opnd,
    output ev_z,
    input  gnt,
    input  ev_x,
    input  done,
    input  result,
    input  busy
  );

  // The arbiter itself.
  modport slave (
    input  req,
    input  opnd,
    input  ev_z,
    output gnt,
    output ev_x,
    output done,
    output result,
    output busy
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, with wrap.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IW-1:0]    idx,
  output logic             any_req
);

  logic found;

  // Scan requesters starting at rr_ptr; the first hit wins.
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      logic [IW-1:0] j;
      j = IW'((32'(rr_ptr) + k) % N_REQ);
      if (!found && req[j]) begin
        found   = 1'b1;
        idx     = j;
        pick[j] = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/sop_eval_arbiter.sv
// Round-robin sequencer sharing one combinational SOP evaluator among N_REQ requesters.
// A granted operand is held on ev_x for SETTLE cycles, then z is captured and returned
// with a one-cycle done pulse to the served requester.
module sop_eval_arbiter
  import sop_arb_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned CW     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  sop_eval_arbiter_if.slave       bus
);

  localparam int unsigned IW = $clog2(N_REQ);

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic [IW-1:0]       rr_ptr_q;
  logic [IW-1:0]       sel_q;
  logic [N_REQ-1:0]    gnt_q;
  logic [OPND_W-1:0]   ev_x_q;
  logic [N_REQ-1:0]    done_q;
  logic                result_q;
  logic                busy_q;

  logic [N_REQ-1:0]    pick;
  logic [IW-1:0]       pick_idx;
  logic                any_req;
  logic [OPND_W-1:0]   opnd_sel;
  logic [IW-1:0]       ptr_next;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .req     (bus.req),
    .rr_ptr  (rr_ptr_q),
    .pick    (pick),
    .idx     (pick_idx),
    .any_req (any_req)
  );

  // Operand of the picked requester; one-hot pick keeps this a plain AND-OR mux.
  always_comb begin
    opnd_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick[i]) begin
        opnd_sel = bus.opnd[i*OPND_W +: OPND_W];
      end
    end
  end

  // Pointer moves just past the served requester so it gets lowest priority next.
  always_comb begin
    if (sel_q == IW'(N_REQ - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = sel_q + IW'(1);
    end
  end

  // Arbitration FSM, settle counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      sel_q    <= '0;
      gnt_q    <= '0;
      ev_x_q   <= '0;
      done_q   <= '0;
      result_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            gnt_q   <= pick;
            ev_x_q  <= opnd_sel;
            sel_q   <= pick_idx;
            cnt_q   <= CW'(SETTLE);
            busy_q  <= 1'b1;
            state_q <= StSettle;
          end
        end
        StSettle: begin
          cnt_q <= cnt_q - CW'(1);
          // Last settle cycle: evaluator inputs have been stable for SETTLE cycles.
          if (cnt_q == CW'(1)) begin
            result_q <= bus.ev_z;
            done_q   <= gnt_q;
            rr_ptr_q <= ptr_next;
            state_q  <= StResp;
          end
        end
        StResp: begin
          // ev_x deliberately keeps its value until the next grant.
          gnt_q   <= '0;
          done_q  <= '0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.ev_x   = ev_x_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.busy   = busy_q;

endmodule
